// File: rtl/uart_tx_axis.sv
// UART transmitter fed by an AXI-Stream byte interface: start, DATA_BITS LSB-first, optional parity, stop.
// Define UART_TX_TWO_STOP_EN to send two stop bits per frame instead of one.
`timescale 1ns/1ps

module uart_tx_axis #(
  parameter int    CLK_FREQ  = 50_000_000,
  parameter int    BAUD      = 115200,
  parameter int    DATA_BITS = 8,
  parameter string PARITY    = "even"
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] s_axis_tdata,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  output logic                 tx,
  output logic                 busy,
  output logic                 tx_done
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD;
  localparam int CNT_W    = $clog2(BAUD_DIV);
  localparam bit PAR_EN   = (PARITY != "none");
  localparam bit PAR_ODD  = (PARITY == "odd");
`ifdef UART_TX_TWO_STOP_EN
  localparam int STOP_BITS = 2;
`else
  localparam int STOP_BITS = 1;
`endif
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);
  localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    START    = 3'd1,
    DATA     = 3'd2,
    PARITY_S = 3'd3,
    STOP     = 3'd4
  } state_t;

  state_t               state, state_d;
  logic [CNT_W-1:0]     baud_cnt, baud_cnt_d;
  logic [3:0]           bit_cnt, bit_cnt_d;
  logic [DATA_BITS-1:0] shift, shift_d;
  logic                 parity_bit, parity_d;
  logic                 tx_d, busy_d, done_d;
  logic                 handshake;
  logic                 baud_end;

  assign s_axis_tready = (state == IDLE) && !rst;
  assign handshake     = s_axis_tvalid && s_axis_tready;
  assign baud_end      = (baud_cnt == BAUD_LAST);

  // Line outputs are registered from the current state, so they trail the state by one clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      parity_bit <= 1'b0;
      tx         <= 1'b1;
      busy       <= 1'b0;
      tx_done    <= 1'b0;
    end else begin
      state      <= state_d;
      baud_cnt   <= baud_cnt_d;
      bit_cnt    <= bit_cnt_d;
      shift      <= shift_d;
      parity_bit <= parity_d;
      tx         <= tx_d;
      busy       <= busy_d;
      tx_done    <= done_d;
    end
  end

  always_comb begin
    state_d    = state;
    baud_cnt_d = baud_cnt;
    bit_cnt_d  = bit_cnt;
    shift_d    = shift;
    parity_d   = parity_bit;
    case (state)
      IDLE: begin
        baud_cnt_d = '0;
        bit_cnt_d  = '0;
        if (handshake) begin
          shift_d  = s_axis_tdata;
          parity_d = PAR_ODD ? ~^s_axis_tdata : ^s_axis_tdata;
          state_d  = START;
        end
      end
      START: begin
        if (baud_end) begin
          baud_cnt_d = '0;
          state_d    = DATA;
        end else begin
          baud_cnt_d = baud_cnt + CNT_W'(1);
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_cnt_d = '0;
          shift_d    = shift >> 1;
          if (bit_cnt == DATA_LAST) begin
            bit_cnt_d = '0;
            state_d   = PAR_EN ? PARITY_S : STOP;
          end else begin
            bit_cnt_d = bit_cnt + 4'd1;
          end
        end else begin
          baud_cnt_d = baud_cnt + CNT_W'(1);
        end
      end
      PARITY_S: begin
        if (baud_end) begin
          baud_cnt_d = '0;
          state_d    = STOP;
        end else begin
          baud_cnt_d = baud_cnt + CNT_W'(1);
        end
      end
      STOP: begin
        // bit_cnt is reused here to count stop bits
        if (baud_end) begin
          baud_cnt_d = '0;
          if (bit_cnt == STOP_LAST) begin
            bit_cnt_d = '0;
            state_d   = IDLE;
          end else begin
            bit_cnt_d = bit_cnt + 4'd1;
          end
        end else begin
          baud_cnt_d = baud_cnt + CNT_W'(1);
        end
      end
      default: begin
        state_d    = IDLE;
        baud_cnt_d = '0;
        bit_cnt_d  = '0;
      end
    endcase
  end

  always_comb begin
    tx_d   = 1'b1;
    busy_d = 1'b0;
    done_d = 1'b0;
    case (state)
      START: begin
        tx_d   = 1'b0;
        busy_d = 1'b1;
      end
      DATA: begin
        tx_d   = shift[0];
        busy_d = 1'b1;
      end
      PARITY_S: begin
        tx_d   = parity_bit;
        busy_d = 1'b1;
      end
      STOP: begin
        busy_d = 1'b1;
        done_d = baud_end && (bit_cnt == STOP_LAST);
      end
      default: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
      end
    endcase
  end

endmodule

// File: doc/uart_tx_axis.md
Name: uart_tx_axis

Overview:
- UART serial transmitter with an AXI-Stream-style byte input.
- Serialises one word per frame: start bit, DATA_BITS data bits LSB first, optional parity bit, stop bit(s).
- Line format matches the team's UART receiver: same CLK_FREQ/BAUD/DATA_BITS/PARITY parameters, same even/odd parity definition.
- Sits between the on-chip stream source and the tx pad; line idles high.

Parameters:
CLK_FREQ, 50_000_000, system clock frequency in Hz
BAUD, 115200, line rate in bit/s; BAUD_DIV = CLK_FREQ/BAUD (integer divide), clocks per bit, must be >= 4
DATA_BITS, 8, data bits per frame (5..9)
PARITY, "even", one of "none", "even", "odd"

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  reset, asynchronous, active-high
s_axis_tdata  input  DATA_BITS  word to transmit
s_axis_tvalid  input  1  source has a word
s_axis_tready  output  1  transmitter can accept a word this cycle
tx  output  1  UART serial line, idle high
busy  output  1  high while a frame is being sent (START through last STOP clock)
tx_done  output  1  one-clk pulse on the last clock of the final stop bit

Behaviour:
- Reset values: tx=1, s_axis_tready=0, busy=0, tx_done=0, state=IDLE, counters=0, shift register=0. tx is driven from a register; no combinational path from input to tx.
- s_axis_tready is 1 exactly when state==IDLE and not in reset.
- Handshake: s_axis_tvalid && s_axis_tready on a clk edge latches tdata into the shift register and computes the parity bit.
  - Even: parity = ^tdata.
  - Odd: parity = ~^tdata.
  - None: no parity bit.
  - The state moves to START on the same edge.
- tdata is don't-care once latched; changes on s_axis_tdata during the frame have no effect.
- State machine, baud_cnt counting 0..BAUD_DIV-1 in every non-IDLE state:
  - IDLE: tx=1, busy=0. On handshake, go to START with baud_cnt=0 and bit_cnt=0.
  - START: tx=0 for exactly BAUD_DIV clocks, then go to DATA.
  - DATA: tx=shift[0] for BAUD_DIV clocks per bit. At baud_cnt==BAUD_DIV-1, shift right and increment bit_cnt. After bit DATA_BITS-1, go to PARITY_S, or to STOP if PARITY=="none".
  - PARITY_S: tx=parity bit for BAUD_DIV clocks, then go to STOP.
  - STOP: tx=1 for BAUD_DIV clocks. On the last clock, pulse tx_done and go to IDLE.
- Latency: tx falls on the first clk edge after the handshake edge.
- Frame length: (2 + DATA_BITS + (PARITY!="none")) * BAUD_DIV clocks, with every bit exactly BAUD_DIV clocks long.
- Back-to-back: tready rises in the IDLE cycle after STOP. With tvalid held high, the next start bit begins 1 clk after the previous stop bit ends, so the line stays high for BAUD_DIV+1 clocks between frames.
- busy is 1 from the first START clock through the last STOP clock inclusive.
- tvalid deasserted while IDLE: no action, tx stays 1.
- Reset mid-frame: tx returns to 1 immediately (asynchronously) and the frame is aborted. No tx_done is issued. After release, the first handshake starts a fresh frame.
- Illegal state encodings recover to IDLE with tx=1.

Optional Feature:
UART_TX_TWO_STOP_EN
- Defined: the STOP state lasts 2*BAUD_DIV clocks (two stop bits). tx_done pulses on the last clock of the second stop bit, and frame length grows by BAUD_DIV.
- Undefined: one stop bit, exactly as described above.
- The ready/handshake rules are unchanged in both cases.

Test Plan:
1. CLK_FREQ=1_000_000, BAUD=100_000 (BAUD_DIV=10), PARITY="even". Send 0xA5 -> tx samples 0,1,0,1,0,0,1,0,1,0,1 at each bit centre. Each bit lasts 10 clocks, frame is 110 clocks, tx_done is a single pulse at clock 110, busy is high for 110 clocks.
2. PARITY="odd", send 0x01 -> parity bit 0. PARITY="even", send 0x01 -> parity bit 1. PARITY="none", send 0x01 -> frame is 100 clocks with no parity slot.
3. Hold tvalid high with words 0x55 then 0x0F -> the second handshake occurs in the IDLE cycle after the first stop bit. Line is high for exactly 11 clocks between frames. tready is 0 throughout each frame.
4. Change s_axis_tdata mid-frame while tvalid=0 -> transmitted bits still match the latched word. tready stays 0 and tvalid is ignored until IDLE.
5. Assert rst during DATA bit 3 -> tx=1 within the same cycle, and busy, tready and tx_done are all 0. After release, send 0x3C -> a correct complete frame.
6. Build with UART_TX_TWO_STOP_EN, send 0xA5 (even parity) -> the stop level lasts 20 clocks, frame is 120 clocks, and tx_done pulses at clock 120.
